stopwatch_ctrl: RTL and testbench

Run-control sequencer for a four-digit cascaded decimal (BCD) counter chain, built from modulo-10 digit stages that wrap from 9 to 0. A prescaler turns the system clock into count ticks, and an FSM handles the start/stop/clear/lap commands. The block ripples carries digit to digit, flags full-scale wrap, and drives a display bus that can optionally be frozen for lap readout. It sits between the panel-button debouncers and the seven-segment display driver.

---
 rtl/stopwatch_ctrl_if.sv | 24 ++
 rtl/stopwatch_ctrl.sv | 145 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Panel/display bundle for stopwatch_ctrl.
// master: button debouncers + display driver side (drives commands, reads count).
// slave : the stopwatch_ctrl block itself.
interface stopwatch_ctrl_if;
    logic        start;
    logic        stop;
    logic        rst_cnt;
    logic        lap;
    logic [15:0] bcd;
    logic [15:0] disp;
    logic        running;
    logic        ovf;
    logic [1:0]  state;

    modport master (
        output start, stop, rst_cnt, lap,
        input  bcd, disp, running, ovf, state
    );

    modport slave (
        input  start, stop, rst_cnt, lap,
        output bcd, disp, running, ovf, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run-control sequencer for a four-digit cascaded BCD stopwatch.
// A prescaler divides clk by DIV into count ticks; an FSM handles
// start/stop/clear/lap; digits ripple carries and flag the 9999->0000 wrap.
// Optional feature macro: STOPWATCH_LAP_EN (lap freeze of the display bus).
module stopwatch_ctrl #(
    parameter int DIV = 10
) (
    input  logic             clk,
    input  logic             clr,
    stopwatch_ctrl_if.slave  sw
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic [15:0]     r_bcd;
    logic            r_running;
    logic            r_ovf;
`ifdef STOPWATCH_LAP_EN
    logic [15:0]     r_cap;
`endif

    logic            w_counting;
    logic            w_tick;
    logic            w_wrap;
    logic [15:0]     w_bcd_next;

    assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_tick     = w_counting && (r_presc == P_LAST);
    assign w_wrap     = (r_bcd == 16'h9999);

    // Next digit values for one tick: digit i advances when all lower digits read 9.
    always_comb begin
        logic v_carry;
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_bcd_next = r_bcd;
        v_carry    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v_carry) begin
                // Codes 10..15 cannot occur, but fold them to 0 rather than 10+.
                w_bcd_next[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd9) ? 4'd0
                                                                  : r_bcd[4*i +: 4] + 4'd1;
            end
            v_carry = v_carry && (r_bcd[4*i +: 4] == 4'd9);
        end
    end

    // FSM, prescaler, digit chain and registered status outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_bcd     <= '0;
            r_running <= 1'b0;
            r_ovf     <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            r_cap     <= '0;
`endif
        end else begin
            r_ovf <= 1'b0;

            // Counting work keys off the pre-edge state, so a tick coinciding
            // with stop still lands.
            if (w_counting) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
                if (w_tick) begin
                    r_bcd <= w_bcd_next;
                    r_ovf <= w_wrap;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (sw.rst_cnt) begin
                        r_bcd <= '0;
                    end else if (sw.start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                        r_presc   <= '0;
                    end
                end
                S_RUN: begin
                    if (sw.stop) begin
                        r_state   <= S_PAUSE;
                        r_running <= 1'b0;
                    end
`ifdef STOPWATCH_LAP_EN
                    else if (sw.lap) begin
                        r_state <= S_LAP;
                        r_cap   <= r_bcd;
                    end
`endif
                end
`ifdef STOPWATCH_LAP_EN
                S_LAP: begin
                    if (sw.stop) begin
                        r_state   <= S_PAUSE;
                        r_running <= 1'b0;
                    end else if (sw.lap) begin
                        r_state <= S_RUN;
                    end
                end
`endif
                S_PAUSE: begin
                    if (sw.rst_cnt) begin
                        r_state <= S_IDLE;
                        r_bcd   <= '0;
                        r_presc <= '0;
                    end else if (sw.start) begin
                        // Prescaler phase is kept so resume continues mid-period.
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign sw.bcd     = r_bcd;
    assign sw.running = r_running;
    assign sw.ovf     = r_ovf;
    assign sw.state   = r_state;
`ifdef STOPWATCH_LAP_EN
    // Display shows the lap snapshot only while in LAP; live count otherwise.
    assign sw.disp    = (r_state == S_LAP) ? r_cap : r_bcd;
`else
    assign sw.disp    = r_bcd;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: DUT A uses DIV=4, DUT B uses DIV=1.
// Table vectors go through an expectation queue; multi-cycle corners are
// hand-written sequences. Lap expectations follow STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    stopwatch_ctrl_if ifa ();
    stopwatch_ctrl_if ifb ();

    stopwatch_ctrl #(.DIV(4)) u_a (.clk(clk), .clr(clr), .sw(ifa));
    stopwatch_ctrl #(.DIV(1)) u_b (.clk(clk), .clr(clr), .sw(ifb));

    typedef struct {
        logic [1:0]  state;
        logic        running;
        logic [15:0] bcd;
        logic [15:0] disp;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic start;
        logic stop;
        logic rst_cnt;
        logic lap;
        exp_t exp;
    } vec_t;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb_q[$];
    vec_t vecs[15];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic sp, input logic rc, input logic lp,
                                input logic [1:0] es, input logic er, input logic [15:0] eb);
        vec_t v;
        v.start = st; v.stop = sp; v.rst_cnt = rc; v.lap = lp;
        v.exp.state = es; v.exp.running = er; v.exp.bcd = eb; v.exp.disp = eb; v.exp.ovf = 1'b0;
        return v;
    endfunction

    task automatic check_a(input string name, input logic [1:0] st, input logic run,
                           input logic [15:0] b, input logic [15:0] d);
        check({name, ".state"},   16'(ifa.state),   16'(st));
        check({name, ".running"}, 16'(ifa.running), 16'(run));
        check({name, ".bcd"},     ifa.bcd,          b);
        check({name, ".disp"},    ifa.disp,         d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [1:0] lap_st;

        // DIV=4 sequence from IDLE with prescaler at 0.
        vecs[0]  = mk(1, 0, 0, 0, 2'd1, 1, 16'h0000); // start
        vecs[1]  = mk(0, 0, 0, 0, 2'd1, 1, 16'h0000);
        vecs[2]  = mk(0, 0, 0, 0, 2'd1, 1, 16'h0000);
        vecs[3]  = mk(0, 0, 0, 0, 2'd1, 1, 16'h0000);
        vecs[4]  = mk(0, 0, 0, 0, 2'd1, 1, 16'h0001); // first tick, 4 edges after start
        vecs[5]  = mk(1, 0, 1, 0, 2'd1, 1, 16'h0001); // start+rst_cnt ignored in RUN
        vecs[6]  = mk(0, 1, 0, 1, 2'd2, 0, 16'h0001); // stop beats lap; prescaler now 2
        vecs[7]  = mk(0, 0, 0, 0, 2'd2, 0, 16'h0001);
        vecs[8]  = mk(1, 0, 0, 0, 2'd1, 1, 16'h0001); // resume, phase kept
        vecs[9]  = mk(0, 0, 0, 0, 2'd1, 1, 16'h0001);
        vecs[10] = mk(0, 0, 0, 0, 2'd1, 1, 16'h0002); // tick 2 edges after resume
        vecs[11] = mk(0, 1, 0, 0, 2'd2, 0, 16'h0002);
        vecs[12] = mk(1, 0, 1, 0, 2'd0, 0, 16'h0000); // rst_cnt beats start in PAUSE
        vecs[13] = mk(0, 0, 1, 0, 2'd0, 0, 16'h0000);
        vecs[14] = mk(1, 0, 0, 0, 2'd1, 1, 16'h0000); // start at edge k

        {ifa.start, ifa.stop, ifa.rst_cnt, ifa.lap} = '0;
        {ifb.start, ifb.stop, ifb.rst_cnt, ifb.lap} = '0;

        // Power-on reset, asserted between edges.
        #2 clr = 1'b0;
        #1;
        check_a("por_a", 2'd0, 1'b0, 16'h0000, 16'h0000);
        check("por_a.ovf", 16'(ifa.ovf), 16'd0);
        #4 clr = 1'b1;
        step();
        check_a("idle_a", 2'd0, 1'b0, 16'h0000, 16'h0000);

        // Table vectors through the expectation queue.
        for (int i = 0; i < 15; i++) begin
            ifa.start   = vecs[i].start;
            ifa.stop    = vecs[i].stop;
            ifa.rst_cnt = vecs[i].rst_cnt;
            ifa.lap     = vecs[i].lap;
            sb_q.push_back(vecs[i].exp);
            step();
            e = sb_q.pop_front();
            check_a($sformatf("vec%0d", i), e.state, e.running, e.bcd, e.disp);
            check($sformatf("vec%0d.ovf", i), 16'(ifa.ovf), 16'(e.ovf));
        end
        {ifa.start, ifa.stop, ifa.rst_cnt, ifa.lap} = '0;

        // Count cadence: start was edge k.
        repeat (3) step();
        check("cad_k3.bcd", ifa.bcd, 16'h0000);
        step();
        check("cad_k4.bcd", ifa.bcd, 16'h0001);
        repeat (32) step();
        check("cad_k36.bcd", ifa.bcd, 16'h0009);
        repeat (4) step();
        check("cad_k40.bcd", ifa.bcd, 16'h0010);

        // Pause with prescaler=2, hold 7 cycles, resume.
        step();
        ifa.stop = 1'b1;
        step();
        ifa.stop = 1'b0;
        check("pause.state", 16'(ifa.state), 16'd2);
        repeat (7) step();
        check("pause_hold.bcd", ifa.bcd, 16'h0010);
        check("pause_hold.state", 16'(ifa.state), 16'd2);
        ifa.start = 1'b1;
        step();
        ifa.start = 1'b0;
        check("resume.running", 16'(ifa.running), 16'd1);
        step();
        check("resume_r1.bcd", ifa.bcd, 16'h0010);
        step();
        check("resume_r2.bcd", ifa.bcd, 16'h0011);

        // Async reset mid-run at 0x0023.
        repeat (48) step();
        check("pre_rst.bcd", ifa.bcd, 16'h0023);
        #2 clr = 1'b0;
        #1;
        check_a("async_rst", 2'd0, 1'b0, 16'h0000, 16'h0000);
        check("async_rst.ovf", 16'(ifa.ovf), 16'd0);
        #3 clr = 1'b1;
        repeat (3) step();
        check_a("post_rst", 2'd0, 1'b0, 16'h0000, 16'h0000);

        // DUT B (DIV=1): pause at 0x0057, then start+rst_cnt.
        ifb.start = 1'b1;
        step();
        ifb.start = 1'b0;
        check("b_start.bcd", ifb.bcd, 16'h0000);
        repeat (56) step();
        ifb.stop = 1'b1;
        step();
        ifb.stop = 1'b0;
        check("b_pause.state", 16'(ifb.state), 16'd2);
        check("b_pause.bcd", ifb.bcd, 16'h0057);
        ifb.start = 1'b1; ifb.rst_cnt = 1'b1;
        step();
        check("b_clr.state", 16'(ifb.state), 16'd0);
        check("b_clr.bcd", ifb.bcd, 16'h0000);
        ifb.rst_cnt = 1'b0;
        step();
        ifb.start = 1'b0; ifb.rst_cnt = 1'b1;
        step();
        ifb.rst_cnt = 1'b0;
        check("b_run_rst.state", 16'(ifb.state), 16'd1);
        check("b_run_rst.bcd", ifb.bcd, 16'h0001);

        // Full-scale wrap.
        repeat (1233) step();
        check("b_mid.bcd", ifb.bcd, 16'h1234);
        repeat (8765) step();
        check("b_9999.bcd", ifb.bcd, 16'h9999);
        check("b_9999.ovf", 16'(ifb.ovf), 16'd0);
        step();
        check("b_wrap.bcd", ifb.bcd, 16'h0000);
        check("b_wrap.ovf", 16'(ifb.ovf), 16'd1);
        step();
        check("b_after.bcd", ifb.bcd, 16'h0001);
        check("b_after.ovf", 16'(ifb.ovf), 16'd0);

        // Lap freeze on DUT A (idle, prescaler 0).
`ifdef STOPWATCH_LAP_EN
        lap_st = 2'd3;
`else
        lap_st = 2'd1;
`endif
        ifa.start = 1'b1;
        step();
        ifa.start = 1'b0;
        repeat (48) step();
        check("lap_pre.bcd", ifa.bcd, 16'h0012);
        step();
        ifa.lap = 1'b1;
        step();
        ifa.lap = 1'b0;
        check_a("lap_in", lap_st, 1'b1, 16'h0012, 16'h0012);
        repeat (10) step();
`ifdef STOPWATCH_LAP_EN
        check_a("lap_hold", 2'd3, 1'b1, 16'h0015, 16'h0012);
`else
        check_a("lap_hold", 2'd1, 1'b1, 16'h0015, 16'h0015);
`endif
        ifa.lap = 1'b1;
        step();
        check_a("lap_out", 2'd1, 1'b1, 16'h0015, 16'h0015);
        step();
        ifa.lap = 1'b0;
        check_a("lap_in2", lap_st, 1'b1, 16'h0015, 16'h0015);
        ifa.stop = 1'b1;
        step();
        ifa.stop = 1'b0;
        check_a("lap_stop", 2'd2, 1'b0, 16'h0015, 16'h0015);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
